bin2bcd_dabble_seq: RTL and testbench

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It processes one input bit per clock. Each cycle it applies one bcd_digit_correct instance per BCD digit, then shifts left by one. Inputs and outputs use valid/ready handshakes, so the block sits between a binary result producer (e.g. the multiplier output) and a decimal display/formatting stage.

---
 rtl/bin2bcd_dabble_seq.sv | 120 ++++++++++++
 tb/tb_bin2bcd_dabble_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_dabble_seq.sv
// Sequential double-dabble binary-to-BCD converter: one input bit per clock,
// valid/ready handshakes on the operand input and the BCD result output.
module bin2bcd_dabble_seq #(
  parameter int BIN_W      = 16,
  parameter int BCD_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BIN_W-1:0]        in_bin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*BCD_DIGITS-1:0] out_bcd,
  output logic                    overflow,
  output logic                    busy
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * BCD_DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_sr_q, bin_sr_d;
  logic [BCD_W-1:0]   bcd_sr_q, bcd_sr_d;
  logic [BCD_W-1:0]   corr_s;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Add-3 correction: a digit >= 5 becomes >= 8 so the following shift carries out.
  function automatic logic [3:0] bcd_digit_correct(input logic [3:0] digit);
    if (digit >= 4'd5) begin
      return digit + 4'd3;
    end else begin
      return digit;
    end
  endfunction

  for (genvar k = 0; k < BCD_DIGITS; k++) begin : g_corr
    assign corr_s[4*k +: 4] = bcd_digit_correct(bcd_sr_q[4*k +: 4]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bin_sr_q <= {BIN_W{1'b0}};
      bcd_sr_q <= {BCD_W{1'b0}};
      ovf_q    <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      bin_sr_q <= bin_sr_d;
      bcd_sr_q <= bcd_sr_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) state_d = SHIFT;
        else          state_d = IDLE;
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(1)) state_d = DONE;
        else                    state_d = SHIFT;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
        else           state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, then correct-and-shift {bcd_sr, bin_sr} once per SHIFT cycle.
  always_comb begin
    bin_sr_d = bin_sr_q;
    bcd_sr_d = bcd_sr_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    if (state_q == IDLE && in_valid) begin
      bin_sr_d = in_bin;
      bcd_sr_d = {BCD_W{1'b0}};
      ovf_d    = 1'b0;
      cnt_d    = CNT_W'(BIN_W);
    end else if (state_q == SHIFT) begin
      bcd_sr_d = {corr_s[BCD_W-2:0], bin_sr_q[BIN_W-1]};
      bin_sr_d = {bin_sr_q[BIN_W-2:0], 1'b0};
      ovf_d    = ovf_q | corr_s[BCD_W-1];
      cnt_d    = cnt_q - CNT_W'(1);
    end else begin
      bin_sr_d = bin_sr_q;
      bcd_sr_d = bcd_sr_q;
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      SHIFT:   busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  assign out_bcd  = bcd_sr_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_dabble_seq.sv
// Directed testbench for bin2bcd_dabble_seq: a 16-bit/5-digit instance and an
// 8-bit/2-digit instance exercising handshakes, reset and truncation.
module tb_bin2bcd_dabble_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, out_valid, out_ready, overflow, busy;
  logic [15:0] in_bin;
  logic [19:0] out_bcd;

  logic        b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_overflow, b_busy;
  logic [7:0]  b_in_bin, b_out_bcd;

  int errors = 0;
  int checks = 0;

  bin2bcd_dabble_seq #(.BIN_W(16), .BCD_DIGITS(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
    .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd),
    .overflow(overflow), .busy(busy)
  );

  bin2bcd_dabble_seq #(.BIN_W(8), .BCD_DIGITS(2)) dut8 (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_bin(b_in_bin),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_bcd(b_out_bcd),
    .overflow(b_overflow), .busy(b_busy)
  );

  // Decimal reference: digit k is (v / 10^k) mod 10.
  function automatic logic [19:0] bcd_model(input int v);
    logic [19:0] r;
    int x;
    r = 20'h0;
    x = v;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Drive one operand into the 16-bit DUT from IDLE, wait (bounded) for the result, then handshake.
  task automatic run16(input logic [15:0] v, output int lat, output logic [19:0] bcd, output logic ovf);
    in_valid = 1'b1;
    in_bin   = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    bcd = out_bcd;
    ovf = overflow;
    @(posedge clk); #1;
  endtask

  task automatic run8(input logic [7:0] v, output int lat, output logic [7:0] bcd, output logic ovf);
    b_in_valid = 1'b1;
    b_in_bin   = v;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    bcd = b_out_bcd;
    ovf = b_overflow;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; b_rst = 1'b1;
    in_valid = 1'b0; b_in_valid = 1'b0;
    out_ready = 1'b1; b_out_ready = 1'b1;
    in_bin = 16'h0; b_in_bin = 8'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; b_rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, expected 1 0 0", in_ready, out_valid, busy);
    end
    checks++;
    if (out_bcd !== 20'h0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: out_bcd=%h overflow=%b, expected 00000 0", out_bcd, overflow);
    end
    checks++;
    if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_busy !== 1'b0 || b_out_bcd !== 8'h0) begin
      errors++;
      $display("FAIL reset_narrow: in_ready=%b out_valid=%b busy=%b out_bcd=%h, expected 1 0 0 00",
               b_in_ready, b_out_valid, b_busy, b_out_bcd);
    end
  endtask

  task automatic test_directed();
    logic [15:0] vin [5]  = '{16'd0, 16'd65535, 16'd9999, 16'd10000, 16'd1};
    logic [19:0] vexp [5] = '{20'h00000, 20'h65535, 20'h09999, 20'h10000, 20'h00001};
    int lat;
    logic [19:0] bcd;
    logic ovf;
    for (int i = 0; i < 5; i++) begin
      run16(vin[i], lat, bcd, ovf);
      checks++;
      if (lat !== 16) begin
        errors++;
        $display("FAIL latency_%0d: got %0d edges, expected 16", vin[i], lat);
      end
      checks++;
      if (bcd !== vexp[i] || ovf !== 1'b0) begin
        errors++;
        $display("FAIL convert_%0d: got %h ovf=%b, expected %h ovf=0", vin[i], bcd, ovf, vexp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bin    = 16'd12345;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_bcd !== 20'h12345 || overflow !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: out_valid=%b out_bcd=%h ovf=%b in_ready=%b busy=%b, expected 1 12345 0 0 0",
                 i, out_valid, out_bcd, overflow, in_ready, busy);
      end
      in_valid = 1'b1;
      in_bin   = 16'd777;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_handshake: in_ready=%b out_valid=%b busy=%b, expected 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_ignore_in_valid();
    int lat;
    int extra;
    in_valid = 1'b1;
    in_bin   = 16'd4321;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (lat == 7) begin
        in_valid = 1'b1;
        in_bin   = 16'd1234;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    checks++;
    if (lat !== 16 || out_bcd !== 20'h04321) begin
      errors++;
      $display("FAIL ignore_result: lat=%0d out_bcd=%h, expected 16 04321", lat, out_bcd);
    end
    @(posedge clk); #1;
    extra = 0;
    repeat (20) begin
      if (out_valid || busy) extra++;
      @(posedge clk); #1;
    end
    checks++;
    if (extra !== 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ignore_no_extra: active cycles=%0d in_ready=%b, expected 0 1", extra, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int extra;
    logic [19:0] bcd;
    logic ovf;
    in_valid = 1'b1;
    in_bin   = 16'd999;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_bcd !== 20'h0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b busy=%b out_bcd=%h ovf=%b, expected 1 0 0 00000 0",
               in_ready, out_valid, busy, out_bcd, overflow);
    end
    extra = 0;
    repeat (20) begin
      if (out_valid || busy) extra++;
      @(posedge clk); #1;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL mid_reset_discard: active cycles=%0d, expected 0", extra);
    end
    run16(16'd42, lat, bcd, ovf);
    checks++;
    if (lat !== 16 || bcd !== 20'h00042 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_42: lat=%0d bcd=%h ovf=%b, expected 16 00042 0", lat, bcd, ovf);
    end
  endtask

  task automatic test_sweep();
    int lat;
    int v;
    logic [19:0] bcd;
    logic ovf;
    for (int i = 0; i < 2000; i++) begin
      v = int'($urandom_range(65535, 0));
      run16(16'(v), lat, bcd, ovf);
      checks++;
      if (bcd !== bcd_model(v) || ovf !== 1'b0 || lat !== 16) begin
        errors++;
        $display("FAIL sweep_%0d: got %h ovf=%b lat=%0d, expected %h ovf=0 lat=16", v, bcd, ovf, lat, bcd_model(v));
      end
    end
  endtask

  task automatic test_narrow();
    logic [7:0] vin [5]  = '{8'd255, 8'd99, 8'd100, 8'd0, 8'd37};
    logic [7:0] vexp [5] = '{8'h55, 8'h99, 8'h00, 8'h00, 8'h37};
    logic       oexp [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int lat;
    logic [7:0] bcd;
    logic ovf;
    for (int i = 0; i < 5; i++) begin
      run8(vin[i], lat, bcd, ovf);
      checks++;
      if (lat !== 8 || bcd !== vexp[i] || ovf !== oexp[i]) begin
        errors++;
        $display("FAIL narrow_%0d: lat=%0d bcd=%h ovf=%b, expected 8 %h %b", vin[i], lat, bcd, ovf, vexp[i], oexp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_ignore_in_valid();
    test_reset_mid();
    test_narrow();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
